// File: rtl/bram_port_arbiter_pkg.sv
// Shared types for the two-port BRAM arbiter.
//   state_t  : controller state (INIT = clearing memory, RUN = serving requests)
//   req_id_t : identifies requester A or B, used for last-grant and response routing
package bram_port_arbiter_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // Bit positions inside the one-hot grant vector.
  localparam int GRANT_A_BIT = 0;
  localparam int GRANT_B_BIT = 1;

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter, purely combinational.
// Ports:
//   req_a, req_b : request lines
//   last_grant   : requester that won the most recent accepted transfer
//   grant        : one-hot grant, bit GRANT_A_BIT = A, bit GRANT_B_BIT = B
module rr_arbiter2
  import bram_port_arbiter_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req_a && req_b) begin
      // On contention the side that did not win last time goes first.
      if (last_grant == REQ_B) begin
        grant[GRANT_A_BIT] = 1'b1;
      end else begin
        grant[GRANT_B_BIT] = 1'b1;
      end
    end else if (req_a) begin
      grant[GRANT_A_BIT] = 1'b1;
    end else if (req_b) begin
      grant[GRANT_B_BIT] = 1'b1;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between two requesters (A and B).
// After reset the whole memory is cleared to zero (INIT), then requests are
// arbitrated round-robin (RUN). Reads return one cycle after acceptance.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   {a,b}_req_valid/ready      : request handshake (ready = grant)
//   {a,b}_req_we/addr/wdata    : request command, address, write data
//   {a,b}_rsp_valid/data       : one-cycle read response per requester
//   mem_wr_en/rd_en/addr/din   : strobes and command to the BRAM
//   mem_dout                   : BRAM registered read data
//   init_done                  : high once the clear sweep has finished
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 1024,
  localparam int ADDR_W = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req_valid,
  output logic                 a_req_ready,
  input  logic                 a_req_we,
  input  logic [ADDR_W-1:0]    a_req_addr,
  input  logic [RAM_WIDTH-1:0] a_req_wdata,
  output logic                 a_rsp_valid,
  output logic [RAM_WIDTH-1:0] a_rsp_data,
  input  logic                 b_req_valid,
  output logic                 b_req_ready,
  input  logic                 b_req_we,
  input  logic [ADDR_W-1:0]    b_req_addr,
  input  logic [RAM_WIDTH-1:0] b_req_wdata,
  output logic                 b_rsp_valid,
  output logic [RAM_WIDTH-1:0] b_rsp_data,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [RAM_WIDTH-1:0] mem_din,
  input  logic [RAM_WIDTH-1:0] mem_dout,
  output logic                 init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  req_id_t           last_grant_q, last_grant_d;
  logic              rsp_valid_q, rsp_valid_d;
  req_id_t           rsp_owner_q, rsp_owner_d;

  logic [1:0] grant;
  logic       run;

  assign run = (state_q == RUN);

  // Requests are masked outside RUN so no grant can leak during the clear sweep.
  rr_arbiter2 u_arb (
    .req_a      (a_req_valid && run),
    .req_b      (b_req_valid && run),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      last_grant_q <= REQ_B;
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= REQ_A;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = 1'b0;
    rsp_owner_d  = rsp_owner_q;
    a_req_ready  = 1'b0;
    b_req_ready  = 1'b0;
    mem_wr_en    = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    init_done    = 1'b0;

    unique case (state_q)
      INIT: begin
        mem_wr_en  = 1'b1;
        mem_addr   = init_cnt_q;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
      end
      RUN: begin
        init_done   = 1'b1;
        a_req_ready = grant[GRANT_A_BIT];
        b_req_ready = grant[GRANT_B_BIT];
        if (grant[GRANT_B_BIT]) begin
          last_grant_d = REQ_B;
          mem_addr     = b_req_addr;
          mem_din      = b_req_wdata;
          mem_wr_en    = b_req_we;
          mem_rd_en    = !b_req_we;
          rsp_valid_d  = !b_req_we;
          rsp_owner_d  = REQ_B;
        end else if (grant[GRANT_A_BIT]) begin
          last_grant_d = REQ_A;
          mem_addr     = a_req_addr;
          mem_din      = a_req_wdata;
          mem_wr_en    = a_req_we;
          mem_rd_en    = !a_req_we;
          rsp_valid_d  = !a_req_we;
          rsp_owner_d  = REQ_A;
        end
      end
      default: ;
    endcase
  end

  // The BRAM output register already aligns with the one-cycle response slot,
  // so data is passed straight through and only the valid is steered.
  assign a_rsp_valid = rsp_valid_q && (rsp_owner_q == REQ_A);
  assign b_rsp_valid = rsp_valid_q && (rsp_owner_q == REQ_B);
  assign a_rsp_data  = mem_dout;
  assign b_rsp_data  = mem_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter with a behavioural BRAM and a
// response scoreboard fed from accepted read transfers.
module tb_bram_port_arbiter;

  localparam int W     = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [AW-1:0] a_req_addr;
  logic [W-1:0]  a_req_wdata, a_rsp_data;
  logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [AW-1:0] b_req_addr;
  logic [W-1:0]  b_req_wdata, b_rsp_data;
  logic          mem_wr_en, mem_rd_en, init_done;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_din, mem_dout;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;
  logic mon_en     = 1'b0;

  typedef struct {
    logic         owner;
    logic [W-1:0] data;
    int           due;
  } sb_entry_t;

  sb_entry_t    sb_q[$];
  logic [W-1:0] bram    [0:DEPTH-1];
  logic [W-1:0] ref_mem [0:DEPTH-1];

  bram_port_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural single-port BRAM with registered read data.
  initial for (int i = 0; i < DEPTH; i++) bram[i] = 8'hA5;
  always @(posedge clk) begin
    if (mem_wr_en) bram[mem_addr] <= mem_din;
    if (mem_rd_en) mem_dout <= bram[mem_addr];
  end

  // Scoreboard: responses checked first, then this cycle's accepted transfers recorded.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].due == cycle) begin
        sb_entry_t e;
        logic act_v, oth_v;
        logic [W-1:0] act_d;
        e     = sb_q.pop_front();
        act_v = e.owner ? b_rsp_valid : a_rsp_valid;
        oth_v = e.owner ? a_rsp_valid : b_rsp_valid;
        act_d = e.owner ? b_rsp_data  : a_rsp_data;
        tests_run++;
        if (act_v !== 1'b1 || oth_v !== 1'b0 || act_d !== e.data) begin
          tests_failed++;
          $display("[TB] FAIL sb_rsp cycle %0d owner %0d: valid=%b other=%b data=%h, required valid=1 other=0 data=%h",
                   cycle, e.owner, act_v, oth_v, act_d, e.data);
        end
      end else begin
        tests_run++;
        if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL sb_no_rsp cycle %0d: a_rsp_valid=%b b_rsp_valid=%b, required 0 0",
                   cycle, a_rsp_valid, b_rsp_valid);
        end
      end
      tests_run++;
      if (a_req_ready && b_req_ready) begin
        tests_failed++;
        $display("[TB] FAIL one_grant cycle %0d: a_ready=1 b_ready=1, required at most one", cycle);
      end
      if (a_req_valid && a_req_ready) begin
        if (a_req_we) ref_mem[a_req_addr] = a_req_wdata;
        else sb_q.push_back('{owner: 1'b0, data: ref_mem[a_req_addr], due: cycle + 1});
      end
      if (b_req_valid && b_req_ready) begin
        if (b_req_we) ref_mem[b_req_addr] = b_req_wdata;
        else sb_q.push_back('{owner: 1'b1, data: ref_mem[b_req_addr], due: cycle + 1});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic we, input logic [AW-1:0] addr, input logic [W-1:0] wd);
    a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [AW-1:0] addr, input logic [W-1:0] wd);
    b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = wd;
  endtask

  // Follows the clear sweep from the current negedge until init_done rises.
  task automatic check_sweep(input string name);
    int   n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (init_done !== 1'b1 && n < 2 * DEPTH) begin
      if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== AW'(n) || mem_din !== '0 ||
          a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin
        if (!bad)
          $display("[TB] FAIL %s_sweep step %0d: wr=%b rd=%b addr=%h din=%h rdy=%b%b, required wr=1 rd=0 addr=%h din=0 rdy=00",
                   name, n, mem_wr_en, mem_rd_en, mem_addr, mem_din, a_req_ready, b_req_ready, AW'(n));
        bad = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    tests_run++;
    if (bad) tests_failed++;
    tests_run++;
    if (n != DEPTH) begin
      tests_failed++;
      $display("[TB] FAIL %s_sweep_len: %0d cycles, required %0d", name, n, DEPTH);
    end
    tests_run++;
    if (init_done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s_init_done: %b, required 1", name, init_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_a(1'b1, 1'b0, 10'h001, 8'h00);
    set_b(1'b1, 1'b0, 10'h002, 8'h00);
    repeat (3) @(negedge clk);
    tests_run++;
    if (init_done !== 1'b0 || mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== '0 ||
        a_req_ready !== 1'b0 || b_req_ready !== 1'b0 || a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: done=%b wr=%b rd=%b addr=%h rdy=%b%b rsp=%b%b, required 0 1 0 000 00 00",
               init_done, mem_wr_en, mem_rd_en, mem_addr, a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid);
    end
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    check_sweep("reset");
    mon_en = 1'b1;
  endtask

  task automatic test_idle();
    step();
    @(negedge clk);
    tests_run++;
    if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle: rdy=%b%b wr=%b rd=%b, required 00 0 0",
               a_req_ready, b_req_ready, mem_wr_en, mem_rd_en);
    end
  endtask

  task automatic test_write_read();
    step();
    set_a(1'b1, 1'b1, 10'h010, 8'h5A);
    @(negedge clk);
    tests_run++;
    if (a_req_ready !== 1'b1 || mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 ||
        mem_addr !== 10'h010 || mem_din !== 8'h5A) begin
      tests_failed++;
      $display("[TB] FAIL a_write: rdy=%b wr=%b rd=%b addr=%h din=%h, required 1 1 0 010 5a",
               a_req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_din);
    end
    step();
    set_a(1'b1, 1'b0, 10'h010, 8'h00);
    @(negedge clk);
    tests_run++;
    if (a_req_ready !== 1'b1 || mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0 || a_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL a_read_issue: rdy=%b rd=%b wr=%b rsp=%b, required 1 1 0 0",
               a_req_ready, mem_rd_en, mem_wr_en, a_rsp_valid);
    end
    step();
    set_a(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests_run++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 8'h5A || b_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL a_read_rsp: valid=%b data=%h b_valid=%b, required 1 5a 0",
               a_rsp_valid, a_rsp_data, b_rsp_valid);
    end
  endtask

  task automatic test_contention();
    // A lone B transfer first, so the first contention goes to A.
    step();
    set_b(1'b1, 1'b0, 10'h010, 8'h00);
    @(negedge clk);
    tests_run++;
    if (b_req_ready !== 1'b1 || a_req_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b_alone: rdy=%b%b, required 01", a_req_ready, b_req_ready);
    end
    step();
    set_a(1'b1, 1'b0, 10'h010, 8'h00);
    set_b(1'b1, 1'b0, 10'h011, 8'h00);
    for (int i = 0; i < 6; i++) begin
      logic exp_a;
      exp_a = (i % 2 == 0);
      @(negedge clk);
      tests_run++;
      if (a_req_ready !== exp_a || b_req_ready !== !exp_a) begin
        tests_failed++;
        $display("[TB] FAIL contend_%0d: rdy=%b%b, required %b%b", i, a_req_ready, b_req_ready, exp_a, !exp_a);
      end
      if (i < 5) step();
    end
    step();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_b_top_addr();
    step();
    set_b(1'b1, 1'b1, 10'h3FF, 8'h33);
    @(negedge clk);
    tests_run++;
    if (b_req_ready !== 1'b1 || mem_wr_en !== 1'b1 || mem_addr !== 10'h3FF || mem_din !== 8'h33) begin
      tests_failed++;
      $display("[TB] FAIL b_write_3ff: rdy=%b wr=%b addr=%h din=%h, required 1 1 3ff 33",
               b_req_ready, mem_wr_en, mem_addr, mem_din);
    end
    step();
    set_b(1'b0, 1'b0, '0, '0);
    set_a(1'b1, 1'b0, 10'h3FF, 8'h00);
    step();
    set_a(1'b1, 1'b0, 10'h3FE, 8'h00);
    @(negedge clk);
    tests_run++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 8'h33) begin
      tests_failed++;
      $display("[TB] FAIL a_read_3ff: valid=%b data=%h, required 1 33", a_rsp_valid, a_rsp_data);
    end
    step();
    set_a(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests_run++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL a_read_3fe: valid=%b data=%h, required 1 00", a_rsp_valid, a_rsp_data);
    end
  endtask

  task automatic test_read_then_write();
    step();
    set_a(1'b1, 1'b0, 10'h020, 8'h00);
    step();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b1, 1'b1, 10'h020, 8'hFF);
    @(negedge clk);
    tests_run++;
    if (b_req_ready !== 1'b1 || a_rsp_valid !== 1'b1 || a_rsp_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL rd_before_wr: b_rdy=%b a_valid=%b a_data=%h, required 1 1 00",
               b_req_ready, a_rsp_valid, a_rsp_data);
    end
    step();
    set_b(1'b0, 1'b0, '0, '0);
    set_a(1'b1, 1'b0, 10'h020, 8'h00);
    step();
    set_a(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests_run++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL rd_after_wr: valid=%b data=%h, required 1 ff", a_rsp_valid, a_rsp_data);
    end
  endtask

  task automatic test_reset_in_flight();
    step();
    set_a(1'b1, 1'b0, 10'h010, 8'h00);
    @(negedge clk);
    tests_run++;
    if (a_req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL inflight_accept: a_rdy=%b, required 1", a_req_ready);
    end
    step();
    mon_en = 1'b0;
    reset  = 1'b1;
    set_a(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests_run++;
    if (a_rsp_valid !== 1'b0 || init_done !== 1'b0 || mem_addr !== '0 || mem_wr_en !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_run: a_valid=%b done=%b addr=%h wr=%b, required 0 0 000 1",
               a_rsp_valid, init_done, mem_addr, mem_wr_en);
    end
    @(negedge clk);
    reset = 1'b0;
    check_sweep("rerun");
    mon_en = 1'b1;
    step();
    set_a(1'b1, 1'b0, 10'h010, 8'h00);
    step();
    set_a(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests_run++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL cleared_after_reset: valid=%b data=%h, required 1 00", a_rsp_valid, a_rsp_data);
    end
  endtask

  initial begin
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    test_reset();
    test_idle();
    test_write_read();
    test_contention();
    test_b_top_addr();
    test_read_then_write();
    test_reset_in_flight();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
